id_ex_skid_latch: RTL and testbench

- Parametrised successor to the decode-stage boundary. It sits between instruction decode and execute.
- Buffers decoded bundles (npc, instruction, register operands, immediate, control word, halt) in a DEPTH-entry circular skid buffer.
- Uses a valid/ready handshake on both sides, with synchronous flush (branch/jump squash) and sticky halt tracking.
- Lets EX stall without combinationally back-propagating ready into decode.

---
 rtl/id_ex_skid_latch.sv | 177 +++++++++++++++++
 tb/tb_id_ex_skid_latch.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_skid_latch.sv
// id_ex_skid_latch: decode-to-execute boundary built as a DEPTH-entry circular skid buffer.
// Valid/ready on both sides; in_ready never depends on out_ready, so an EX stall does not
// ripple combinationally back into decode. Synchronous flush squashes all entries; a
// pushed halt bundle stops intake until flushed.
// Optional build macro PERF_CNT_EN adds stall/bubble/flush counters and their output ports.
module id_ex_skid_latch #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CTRL_W = 16,
    parameter int unsigned DEPTH  = 2
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      in_npc,
    input  logic [DATA_W-1:0]      in_imemload,
    input  logic [DATA_W-1:0]      in_rdat1,
    input  logic [DATA_W-1:0]      in_rdat2,
    input  logic [DATA_W-1:0]      in_imme,
    input  logic [CTRL_W-1:0]      in_ctrl,
    input  logic                   in_halt,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      out_npc,
    output logic [DATA_W-1:0]      out_imemload,
    output logic [DATA_W-1:0]      out_rdat1,
    output logic [DATA_W-1:0]      out_rdat2,
    output logic [DATA_W-1:0]      out_imme,
    output logic [CTRL_W-1:0]      out_ctrl,
    output logic                   out_halt,
    output logic                   halted,
    output logic                   drained,
    output logic [$clog2(DEPTH):0] count
`ifdef PERF_CNT_EN
    ,
    output logic [31:0]            perf_stall,
    output logic [31:0]            perf_bubble,
    output logic [31:0]            perf_flush
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] npc_mem     [DEPTH];
    logic [DATA_W-1:0] imemload_mem[DEPTH];
    logic [DATA_W-1:0] rdat1_mem   [DEPTH];
    logic [DATA_W-1:0] rdat2_mem   [DEPTH];
    logic [DATA_W-1:0] imme_mem    [DEPTH];
    logic [CTRL_W-1:0] ctrl_mem    [DEPTH];
    logic              halt_mem    [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             halted_q, halted_d;
    logic             push, pop;

    // Flush blocks intake so a bundle presented alongside it is dropped.
    assign in_ready  = (count_q < CNT_W'(DEPTH)) && !halted_q && !flush;
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Next-state for pointers, occupancy and halt tracking; flush overrides everything.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        halted_d = halted_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            halted_d = 1'b0;
        end else begin
            // Pointers wrap by natural overflow since DEPTH is a power of two.
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
            if (push && in_halt) begin
                halted_d = 1'b1;
            end
        end
    end

    // Control state registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            halted_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            halted_q <= halted_d;
        end
    end

    // Bundle storage; zeroed on reset so the head reads zero immediately, untouched by flush.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                npc_mem[i]      <= '0;
                imemload_mem[i] <= '0;
                rdat1_mem[i]    <= '0;
                rdat2_mem[i]    <= '0;
                imme_mem[i]     <= '0;
                ctrl_mem[i]     <= '0;
                halt_mem[i]     <= 1'b0;
            end
        end else if (push) begin
            npc_mem[wr_ptr_q]      <= in_npc;
            imemload_mem[wr_ptr_q] <= in_imemload;
            rdat1_mem[wr_ptr_q]    <= in_rdat1;
            rdat2_mem[wr_ptr_q]    <= in_rdat2;
            imme_mem[wr_ptr_q]     <= in_imme;
            ctrl_mem[wr_ptr_q]     <= in_ctrl;
            halt_mem[wr_ptr_q]     <= in_halt;
        end
    end

    // Head fields come straight from storage, so they are registered; stale when empty.
    assign out_npc      = npc_mem[rd_ptr_q];
    assign out_imemload = imemload_mem[rd_ptr_q];
    assign out_rdat1    = rdat1_mem[rd_ptr_q];
    assign out_rdat2    = rdat2_mem[rd_ptr_q];
    assign out_imme     = imme_mem[rd_ptr_q];
    assign out_ctrl     = ctrl_mem[rd_ptr_q];
    assign out_halt     = halt_mem[rd_ptr_q];

    assign halted  = halted_q;
    assign drained = halted_q && (count_q == '0);
    assign count   = count_q;

`ifdef PERF_CNT_EN
    logic [31:0] stall_cnt_q, bubble_cnt_q, flush_cnt_q;

    // Performance counters; stall/bubble clear on flush, flush_cnt keeps counting across flushes.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            if (flush) begin
                stall_cnt_q  <= '0;
                bubble_cnt_q <= '0;
                flush_cnt_q  <= flush_cnt_q + 32'd1;
            end else begin
                if (in_valid && !in_ready) begin
                    stall_cnt_q <= stall_cnt_q + 32'd1;
                end
                if (out_ready && !out_valid) begin
                    bubble_cnt_q <= bubble_cnt_q + 32'd1;
                end
            end
        end
    end

    assign perf_stall  = stall_cnt_q;
    assign perf_bubble = bubble_cnt_q;
    assign perf_flush  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_skid_latch.sv
// Testbench for id_ex_skid_latch: directed scenarios plus randomized traffic, checked
// against a queue-based reference model with a decoupled pop-side monitor.
module tb_id_ex_skid_latch;

    localparam int DEPTH = 2;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_npc = '0, in_imemload = '0, in_rdat1 = '0, in_rdat2 = '0, in_imme = '0;
    logic [15:0] in_ctrl = '0;
    logic        in_halt = 1'b0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_npc, out_imemload, out_rdat1, out_rdat2, out_imme;
    logic [15:0] out_ctrl;
    logic        out_halt;
    logic        halted;
    logic        drained;
    logic [1:0]  count;

    id_ex_skid_latch #(
        .DATA_W(32),
        .CTRL_W(16),
        .DEPTH (DEPTH)
    ) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_npc      (in_npc),
        .in_imemload (in_imemload),
        .in_rdat1    (in_rdat1),
        .in_rdat2    (in_rdat2),
        .in_imme     (in_imme),
        .in_ctrl     (in_ctrl),
        .in_halt     (in_halt),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_npc     (out_npc),
        .out_imemload(out_imemload),
        .out_rdat1   (out_rdat1),
        .out_rdat2   (out_rdat2),
        .out_imme    (out_imme),
        .out_ctrl    (out_ctrl),
        .out_halt    (out_halt),
        .halted      (halted),
        .drained     (drained),
        .count       (count)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [31:0] npc;
        logic [31:0] iml;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] imm;
        logic [15:0] ctrl;
        logic        halt;
    } bundle_t;

    bundle_t exp_q[$];
    int      checks = 0;
    int      errors = 0;
    int      ref_cnt = 0;
    bit      ref_halted = 1'b0;

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic bundle_t mk(input logic [31:0] npc, input logic h);
        bundle_t b;
        b.npc  = npc;
        b.iml  = $urandom;
        b.r1   = $urandom;
        b.r2   = $urandom;
        b.imm  = $urandom;
        b.ctrl = 16'($urandom);
        b.halt = h;
        return b;
    endfunction

    // One clock: drive inputs after the edge, check state against the model, then advance it.
    task automatic cycle(input logic v, input bundle_t b, input logic fl, input logic ordy);
        bit exp_ready, do_push, do_pop;
        @(posedge CLK);
        #1;
        in_valid = v;
        {in_npc, in_imemload, in_rdat1, in_rdat2, in_imme, in_ctrl, in_halt} = b;
        flush     = fl;
        out_ready = ordy;
        #1;
        exp_ready = (ref_cnt < DEPTH) && !ref_halted && !fl;
        check("in_ready", 256'(in_ready), 256'(exp_ready));
        check("out_valid", 256'(out_valid), 256'(ref_cnt != 0));
        check("count", 256'(count), 256'(ref_cnt));
        check("halted", 256'(halted), 256'(ref_halted));
        check("drained", 256'(drained), 256'(ref_halted && ref_cnt == 0));
        if (fl) begin
            ref_cnt    = 0;
            ref_halted = 1'b0;
            exp_q.delete();
        end else begin
            do_pop  = (ref_cnt > 0) && ordy;
            do_push = v && exp_ready;
            if (do_push) begin
                exp_q.push_back(b);
                if (b.halt) ref_halted = 1'b1;
            end
            ref_cnt = ref_cnt + int'(do_push) - int'(do_pop);
        end
    endtask

    task automatic idle(input logic ordy);
        cycle(1'b0, '0, 1'b0, ordy);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_count"}, 256'(count), 256'(0));
        check({tag, "_out_valid"}, 256'(out_valid), 256'(0));
        check({tag, "_in_ready"}, 256'(in_ready), 256'(1));
        check({tag, "_halted"}, 256'(halted), 256'(0));
        check({tag, "_drained"}, 256'(drained), 256'(0));
        check({tag, "_fields"},
              256'({out_npc, out_imemload, out_rdat1, out_rdat2, out_imme, out_ctrl, out_halt}),
              256'(0));
    endtask

    // Pop-side monitor: whenever EX takes the head, it must match the oldest expected bundle.
    always @(negedge CLK) begin
        bundle_t got;
        if (nRST && out_valid && out_ready && !flush) begin
            got = {out_npc, out_imemload, out_rdat1, out_rdat2, out_imme, out_ctrl, out_halt};
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected: got %0h expected no entry at %0t", got, $time);
            end else begin
                check("pop_bundle", 256'(got), 256'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset is visible before any clock edge is used.
        #3;
        check_reset_outputs("reset");
        #4 nRST = 1'b1;

        // Streaming: one cycle latency, occupancy stays at one.
        cycle(1'b1, mk(32'h4, 1'b0), 1'b0, 1'b1);
        cycle(1'b1, mk(32'h8, 1'b0), 1'b0, 1'b1);
        cycle(1'b1, mk(32'hC, 1'b0), 1'b0, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Backpressure: third bundle refused until the first pop has happened.
        cycle(1'b1, mk(32'h100, 1'b0), 1'b0, 1'b0);
        cycle(1'b1, mk(32'h104, 1'b0), 1'b0, 1'b0);
        begin
            bundle_t third = mk(32'h108, 1'b0);
            cycle(1'b1, third, 1'b0, 1'b0);
            cycle(1'b1, third, 1'b0, 1'b1);
            cycle(1'b1, third, 1'b0, 1'b1);
        end
        repeat (3) idle(1'b1);

        // Simultaneous push and pop at count one, enough iterations to wrap the pointers.
        cycle(1'b1, mk(32'h200, 1'b0), 1'b0, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b1, mk(32'h200 + 32'(4 * i), 1'b0), 1'b0, 1'b1);
        end
        repeat (2) idle(1'b1);

        // Flush while full with a push pending: the pending bundle is dropped.
        cycle(1'b1, mk(32'h300, 1'b0), 1'b0, 1'b0);
        cycle(1'b1, mk(32'h304, 1'b0), 1'b0, 1'b0);
        cycle(1'b1, mk(32'h308, 1'b0), 1'b1, 1'b1);
        cycle(1'b1, mk(32'h30C, 1'b0), 1'b0, 1'b1);
        repeat (2) idle(1'b1);

        // Halt: later bundle refused, drained once the halt entry leaves.
        cycle(1'b1, mk(32'h3C, 1'b1), 1'b0, 1'b0);
        cycle(1'b1, mk(32'h40, 1'b0), 1'b0, 1'b0);
        cycle(1'b1, mk(32'h40, 1'b0), 1'b0, 1'b1);
        idle(1'b1);
        idle(1'b1);
        cycle(1'b0, '0, 1'b1, 1'b0);

        // Halt squashed by a flush before it pops: drained must stay low.
        cycle(1'b1, mk(32'h3C, 1'b1), 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // Asynchronous reset mid-run with two entries buffered.
        cycle(1'b1, mk(32'h500, 1'b0), 1'b0, 1'b0);
        cycle(1'b1, mk(32'h504, 1'b0), 1'b0, 1'b0);
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
        check("count_pre_reset", 256'(count), 256'(2));
        #2 nRST = 1'b0;
        #1;
        check_reset_outputs("midreset");
        ref_cnt    = 0;
        ref_halted = 1'b0;
        exp_q.delete();
        #2 nRST = 1'b1;

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 3) != 0,
                  mk($urandom, $urandom_range(0, 19) == 0),
                  $urandom_range(0, 15) == 0,
                  $urandom_range(0, 2) != 0);
        end

        // Clear any halt and empty the buffer.
        cycle(1'b0, '0, 1'b1, 1'b1);
        repeat (3) idle(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
